ex_fwd_sel_ctrl: RTL and testbench

//  Generates the registered 2-bit select codes for the two EX-stage 4:1 x 32-bit operand muxes.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/ex_fwd_sel_ctrl_fwd_match.sv | 20 ++
 rtl/ex_fwd_sel_ctrl.sv | 147 ++++++++++++++
 tb/tb_ex_fwd_sel_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the EX-stage operand-select controller: select
// codes, the pipeline scoreboard slot record and the select priority helper.
package pipe_ctrl_pkg;

    // Scoreboard rd field is sized for the widest register file we support;
    // narrower indices are zero-extended on entry.
    localparam int SLOT_RD_W = 8;

    // Operand mux select codes
    localparam logic [1:0] SEL_RF    = 2'b00;  // register file read data
    localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB write-back data
    localparam logic [1:0] SEL_ALT   = 2'b11;  // PC (operand A) or immediate (operand B)

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } slot_t;

    // Select priority for one operand: PC/imm override, then the nearer
    // producer (ID/EX, which is in EX/MEM next cycle), then the farther one.
    function automatic logic [1:0] pick_sel(
        input logic alt,
        input logic match_near,
        input logic match_far,
        input logic fwd_on
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (alt)
            sel = SEL_ALT;
        else if (match_near && fwd_on)
            sel = SEL_EXMEM;
        else if (match_far && fwd_on)
            sel = SEL_MEMWB;
        return sel;
    endfunction

endpackage

// File: rtl/ex_fwd_sel_ctrl_fwd_match.sv
// Combinational RAW match of one ID source register against one scoreboard
// slot. Register 0 is hard-wired zero and never matches.
import pipe_ctrl_pkg::*;

module fwd_match (
    input  logic                 slot_valid,
    input  logic                 slot_regwrite,
    input  logic [SLOT_RD_W-1:0] slot_rd,
    input  logic [SLOT_RD_W-1:0] rs,
    input  logic                 src_used,
    output logic                 match
);

    // Match only a live producer that writes the same non-zero register
    always_comb begin
        match = slot_valid & slot_regwrite & src_used
              & (slot_rd == rs) & (rs != '0);
    end

endmodule

// File: rtl/ex_fwd_sel_ctrl.sv
// EX-stage operand select controller. Tracks the ID/EX, EX/MEM and MEM/WB
// producers, registers the two operand mux selects so they line up with the
// instruction in EX, raises load-use / no-forward stalls toward IF/ID and
// counts stalled cycles with a saturating counter.
import pipe_ctrl_pkg::*;

module ex_fwd_sel_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_a_pc,
    input  logic                  id_b_imm,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    input  logic                  dcache_stall,
    output logic [1:0]            ex_sel_a,
    output logic [1:0]            ex_sel_b,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic FWD_ON = (FWD_EN != 0);

    slot_t                idex_reg, exmem_reg, memwb_reg;
    slot_t                id_slot;
    logic [1:0]           sel_a_reg, sel_b_reg;
    logic [1:0]           sel_a_next, sel_b_next;
    logic [CNT_W-1:0]     stall_cnt_reg;
    logic [SLOT_RD_W-1:0] rs1_ext, rs2_ext, rd_ext;
    logic                 used_a, used_b;
    logic                 load_use, raw_nofwd, hz;

    // Comparator fabric: index gi = slot*2 + source
    // (0: ID/EX-A, 1: ID/EX-B, 2: EX/MEM-A, 3: EX/MEM-B)
    slot_t                cmp_slot [2];
    logic [SLOT_RD_W-1:0] cmp_rs   [2];
    logic [1:0]           cmp_used;
    logic [3:0]           match_vec;

    // MEM/WB is tracked for a complete scoreboard but never bypassed from:
    // the register file is write-first, so its data is already visible.
    logic memwb_unused;
    assign memwb_unused = ^memwb_reg;

    // Widen ID register indices to the scoreboard rd width
    always_comb begin
        rs1_ext = '0;
        rs2_ext = '0;
        rd_ext  = '0;
        rs1_ext[REG_ADDR_W-1:0] = id_rs1;
        rs2_ext[REG_ADDR_W-1:0] = id_rs2;
        rd_ext[REG_ADDR_W-1:0]  = id_rd;
    end

    // A source only counts when it is read and not replaced by PC/imm
    always_comb begin
        used_a           = id_use_rs1 & ~id_a_pc;
        used_b           = id_use_rs2 & ~id_b_imm;
        cmp_slot[0]      = idex_reg;
        cmp_slot[1]      = exmem_reg;
        cmp_rs[0]        = rs1_ext;
        cmp_rs[1]        = rs2_ext;
        cmp_used         = {used_b, used_a};
        id_slot.valid    = id_valid;
        id_slot.rd       = rd_ext;
        id_slot.regwrite = id_regwrite;
        id_slot.memread  = id_memread;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_match
            fwd_match u_match (
                .slot_valid    (cmp_slot[gi/2].valid),
                .slot_regwrite (cmp_slot[gi/2].regwrite),
                .slot_rd       (cmp_slot[gi/2].rd),
                .rs            (cmp_rs[gi%2]),
                .src_used      (cmp_used[gi%2]),
                .match         (match_vec[gi])
            );
        end
    endgenerate

    // Hazard detection, stall/bubble requests and the next operand selects
    always_comb begin
        load_use    = id_valid & idex_reg.memread & (match_vec[0] | match_vec[1]);
        raw_nofwd   = ~FWD_ON & id_valid & (|match_vec);
        hz          = load_use | raw_nofwd;
        stall_ifid  = dcache_stall | (hz & ~flush);
        bubble_idex = ~dcache_stall & (hz | flush);
        sel_a_next  = pick_sel(id_a_pc,  match_vec[0], match_vec[2], FWD_ON);
        sel_b_next  = pick_sel(id_b_imm, match_vec[1], match_vec[3], FWD_ON);
    end

    // Scoreboard shift and select registers: freeze > bubble > advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_reg  <= '0;
            exmem_reg <= '0;
            memwb_reg <= '0;
            sel_a_reg <= SEL_RF;
            sel_b_reg <= SEL_RF;
        end else if (dcache_stall) begin
            idex_reg  <= idex_reg;
            exmem_reg <= exmem_reg;
            memwb_reg <= memwb_reg;
            sel_a_reg <= sel_a_reg;
            sel_b_reg <= sel_b_reg;
        end else if (bubble_idex) begin
            idex_reg  <= '0;
            exmem_reg <= idex_reg;
            memwb_reg <= exmem_reg;
            sel_a_reg <= SEL_RF;
            sel_b_reg <= SEL_RF;
        end else begin
            idex_reg  <= id_slot;
            exmem_reg <= idex_reg;
            memwb_reg <= exmem_reg;
            sel_a_reg <= sel_a_next;
            sel_b_reg <= sel_b_next;
        end
    end

    // Saturating count of cycles in which IF/ID is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (stall_ifid && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end

    assign ex_sel_a     = sel_a_reg;
    assign ex_sel_b     = sel_b_reg;
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_ex_fwd_sel_ctrl.sv
// Directed bench for ex_fwd_sel_ctrl. Three instances share the stimulus:
// a forwarding build, a no-forwarding build and a forwarding build with a
// 2-bit counter to reach saturation quickly.
`timescale 1ns/1ps
module tb_ex_fwd_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_a_pc, id_b_imm;
    logic       id_regwrite, id_memread;
    logic       flush, dcache_stall;

    logic [1:0]  sel_a_f, sel_b_f, sel_a_n, sel_b_n, sel_a_s, sel_b_s;
    logic        stall_f, bubble_f, stall_n, bubble_n, stall_s, bubble_s;
    logic [31:0] cnt_f, cnt_n;
    logic [1:0]  cnt_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ex_fwd_sel_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(32)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .dcache_stall(dcache_stall), .ex_sel_a(sel_a_f), .ex_sel_b(sel_b_f),
        .stall_ifid(stall_f), .bubble_idex(bubble_f), .stall_cycles(cnt_f)
    );

    ex_fwd_sel_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .CNT_W(32)) dut_nofwd (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .dcache_stall(dcache_stall), .ex_sel_a(sel_a_n), .ex_sel_b(sel_b_n),
        .stall_ifid(stall_n), .bubble_idex(bubble_n), .stall_cycles(cnt_n)
    );

    ex_fwd_sel_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .dcache_stall(dcache_stall), .ex_sel_a(sel_a_s), .ex_sel_b(sel_b_s),
        .stall_ifid(stall_s), .bubble_idex(bubble_s), .stall_cycles(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic apc, input logic bimm,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs1      = r1;
        id_rs2      = r2;
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_a_pc     = apc;
        id_b_imm    = bimm;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // One clock transaction; outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: v=%0d rs1=%0d rs2=%0d rd=%0d flush=%0d dstall=%0d | fwd sel=%0d/%0d stall=%0d bub=%0d cnt=%0d | nofwd sel=%0d/%0d stall=%0d cnt=%0d | sat cnt=%0d",
                 cyc, id_valid, id_rs1, id_rs2, id_rd, flush, dcache_stall,
                 sel_a_f, sel_b_f, stall_f, bubble_f, cnt_f, sel_a_n, sel_b_n, stall_n, cnt_n, cnt_s);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        dcache_stall = 1'b0;
        nop();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        dcache_stall = 1'b0;
        nop();
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_sel_a", 32'(sel_a_f), 32'd0);
        chk("rst_sel_b", 32'(sel_b_f), 32'd0);
        chk("rst_stall", 32'(stall_f), 32'd0);
        chk("rst_bubble", 32'(bubble_f), 32'd0);
        chk("rst_cnt", cnt_f, 32'd0);

        // 1: add x5,x1,x2 ; add x6,x5,x1 -> EX/MEM bypass on A, no stall
        drive(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd5, 1, 0);
        #1 chk("t1_stall_first", 32'(stall_f), 32'd0);
        tick();
        drive(1, 5'd5, 5'd1, 1, 1, 0, 0, 5'd6, 1, 0);
        #1 chk("t1_stall_dep", 32'(stall_f), 32'd0);
        chk("t1_sel_a_first", 32'(sel_a_f), 32'd0);
        tick();
        nop();
        chk("t1_sel_a", 32'(sel_a_f), 32'd1);
        chk("t1_sel_b", 32'(sel_b_f), 32'd0);
        chk("t1_cnt", cnt_f, 32'd0);

        // 2: lw x5,0(x1) ; add x6,x5,x1 -> one stall + bubble, then MEM/WB data
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd5, 1, 1);
        #1 chk("t2_stall_lw", 32'(stall_f), 32'd0);
        tick();
        drive(1, 5'd5, 5'd1, 1, 1, 0, 0, 5'd6, 1, 0);
        #1 chk("t2_stall_hz", 32'(stall_f), 32'd1);
        chk("t2_bubble_hz", 32'(bubble_f), 32'd1);
        tick();
        chk("t2_stall_after", 32'(stall_f), 32'd0);
        chk("t2_bubble_after", 32'(bubble_f), 32'd0);
        chk("t2_sel_a_bubble", 32'(sel_a_f), 32'd0);
        tick();
        nop();
        chk("t2_sel_a", 32'(sel_a_f), 32'd2);
        chk("t2_sel_b", 32'(sel_b_f), 32'd0);
        chk("t2_cnt", cnt_f, 32'd1);

        // 3: add x0,x1,x2 ; or x7,x0,x0 -> x0 never forwarded
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 1, 0);
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 0, 0, 5'd7, 1, 0);
        #1 chk("t3_stall", 32'(stall_f), 32'd0);
        tick();
        nop();
        chk("t3_sel_a", 32'(sel_a_f), 32'd0);
        chk("t3_sel_b", 32'(sel_b_f), 32'd0);

        // 4: lw x5 ; dependent add squashed by flush in the hazard cycle
        do_reset();
        drive(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd5, 1, 1);
        tick();
        drive(1, 5'd5, 5'd1, 1, 1, 0, 0, 5'd6, 1, 0);
        flush = 1'b1;
        #1 chk("t4_stall", 32'(stall_f), 32'd0);
        chk("t4_bubble", 32'(bubble_f), 32'd1);
        tick();
        flush = 1'b0;
        nop();
        #1 chk("t4_stall_next", 32'(stall_f), 32'd0);
        chk("t4_sel_a", 32'(sel_a_f), 32'd0);
        tick();
        chk("t4_cnt", cnt_f, 32'd0);

        // 5: D-cache freeze for 3 cycles with sub x8,x6,x5 waiting in ID
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 5'd1, 1, 1, 0, 0, 5'd6, 1, 0);
        tick();
        chk("t5_sel_a_pre", 32'(sel_a_f), 32'd1);
        drive(1, 5'd6, 5'd5, 1, 1, 0, 0, 5'd8, 1, 0);
        dcache_stall = 1'b1;
        #1 chk("t5_stall", 32'(stall_f), 32'd1);
        chk("t5_bubble", 32'(bubble_f), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_frz_sel_a", 32'(sel_a_f), 32'd1);
            chk("t5_frz_sel_b", 32'(sel_b_f), 32'd0);
        end
        chk("t5_cnt_frz", cnt_f, 32'd3);
        dcache_stall = 1'b0;
        #1 chk("t5_stall_rel", 32'(stall_f), 32'd0);
        tick();
        nop();
        chk("t5_sub_sel_a", 32'(sel_a_f), 32'd1);
        chk("t5_sub_sel_b", 32'(sel_b_f), 32'd2);
        chk("t5_cnt", cnt_f, 32'd3);

        // 6: no-forward build, add x5 ; sub x6,x5,x2 -> 2 stall cycles, then regfile
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 0, 0, 5'd5, 1, 0);
        #1 chk("t6_stall_first", 32'(stall_n), 32'd0);
        tick();
        drive(1, 5'd5, 5'd2, 1, 1, 0, 0, 5'd6, 1, 0);
        #1 chk("t6_stall_c1", 32'(stall_n), 32'd1);
        chk("t6_bubble_c1", 32'(bubble_n), 32'd1);
        tick();
        chk("t6_stall_c2", 32'(stall_n), 32'd1);
        tick();
        chk("t6_stall_c3", 32'(stall_n), 32'd0);
        tick();
        nop();
        chk("t6_sel_a", 32'(sel_a_n), 32'd0);
        chk("t6_cnt", cnt_n, 32'd2);

        // 6b: addi x5,x1,imm ; sub x6,x5,x2 then reset while stalled
        drive(1, 5'd1, 5'd0, 1, 0, 0, 1, 5'd5, 1, 0);
        tick();
        drive(1, 5'd5, 5'd2, 1, 1, 0, 0, 5'd6, 1, 0);
        #1 chk("t6r_stall_pre", 32'(stall_n), 32'd1);
        chk("t6r_sel_b_pre", 32'(sel_b_n), 32'd3);
        rst_n = 1'b0;
        #1 chk("t6r_stall", 32'(stall_n), 32'd0);
        chk("t6r_bubble", 32'(bubble_n), 32'd0);
        chk("t6r_sel_a", 32'(sel_a_n), 32'd0);
        chk("t6r_sel_b", 32'(sel_b_n), 32'd0);
        chk("t6r_cnt", cnt_n, 32'd0);
        nop();
        rst_n = 1'b1;
        tick();

        // 7: counter saturation with a 2-bit counter after 5 frozen cycles
        do_reset();
        dcache_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        dcache_stall = 1'b0;
        #1 chk("t7_cnt_sat", 32'(cnt_s), 32'd3);
        chk("t7_cnt_wide", cnt_f, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
